// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Run-control, RAW-hazard stall, branch flush and drain/halt
//             sequencer for a 5-stage in-order pipeline without forwarding.
//             Clears the register bank after reset, then tracks pending
//             register writes with per-register saturating counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int NREG   = 32,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32,
   parameter int SB_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rn,
   input  logic [REG_W-1:0]  id_rm,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_use_rn,
   input  logic              id_use_rm,
   input  logic              id_reg_write,
   input  logic              ex_branch_taken,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic              halt_req,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              init_we,
   output logic [REG_W-1:0]  init_addr,
   output logic [DATA_W-1:0] init_data,
   output logic              ready,
   output logic              halted,
   output logic              sb_err
);

   localparam int              SB_W     = $clog2(SB_MAX + 1);
   localparam logic [SB_W-1:0] C_SB_MAX = SB_W'(SB_MAX);
   localparam logic [REG_W-1:0] C_LAST  = REG_W'(NREG - 1);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_init_we;
   logic [REG_W-1:0]    r_cnt;
   logic [SB_W-1:0]     r_sb [NREG];
   logic [2:0]          r_iss;
   logic                r_sb_err;

   logic [SB_W-1:0]     w_sb_next [NREG];
   logic [NREG-1:0]     w_sb_busy;
   logic [NREG-1:0]     w_inc;
   logic [NREG-1:0]     w_dec;
   logic                w_sb_err;
   logic                w_hazard;
   logic                w_issue;
   logic                w_drained;

   // RAW hazard on registered counters only: a WB in this cycle does not
   // release the stall until the following cycle.
   assign w_hazard = id_valid & ((id_use_rn & (r_sb[id_rn] != '0)) |
                                 (id_use_rm & (r_sb[id_rm] != '0)) |
                                 (id_reg_write & (r_sb[id_rd] == C_SB_MAX)));

   assign w_issue   = id_valid & ~id_ex_bubble;
   assign w_drained = (r_iss == 3'b000) & ~|w_sb_busy;

   assign init_we   = r_init_we;
   assign init_addr = r_cnt;
   assign init_data = '0;
   assign ready     = (r_state == S_RUN);
   assign halted    = (r_state == S_HALTED);
   assign sb_err    = r_sb_err;

   // Pipeline control: branch flush beats hazard stall; everything outside
   // RUN holds the front end unless a taken branch must still be redirected.
   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      case (r_state)
         S_RUN: begin
            if (ex_branch_taken) begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
            end else if (!w_hazard) begin
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               id_ex_bubble = 1'b0;
            end
         end
         S_DRAIN: begin
            if (ex_branch_taken) begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Scoreboard next values: saturate at both ends and flag the misuse;
   // an increment and decrement of the same register cancel out.
   always_comb begin
      w_sb_next = r_sb;
      w_sb_busy = '0;
      w_inc     = '0;
      w_dec     = '0;
      w_sb_err  = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         w_inc[i]     = w_issue & id_reg_write & (id_rd == REG_W'(i));
         w_dec[i]     = wb_reg_write & (wb_rd == REG_W'(i));
         w_sb_busy[i] = (r_sb[i] != '0);
         if (w_inc[i] && !w_dec[i]) begin
            if (r_sb[i] == C_SB_MAX) w_sb_err = 1'b1;
            else                     w_sb_next[i] = r_sb[i] + SB_W'(1);
         end else if (w_dec[i] && !w_inc[i]) begin
            if (r_sb[i] == '0) w_sb_err = 1'b1;
            else               w_sb_next[i] = r_sb[i] - SB_W'(1);
         end
      end
   end

   // Sequencer state, init counter, scoreboard and EX/MEM/WB occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_INIT;
         r_init_we <= 1'b0;
         r_cnt     <= '0;
         r_iss     <= 3'b000;
         r_sb_err  <= 1'b0;
         for (int i = 0; i < NREG; i++) r_sb[i] <= '0;
      end else begin
         r_iss <= {r_iss[1:0], w_issue};
         r_sb  <= w_sb_next;
         if (w_sb_err) r_sb_err <= 1'b1;
         case (r_state)
            S_INIT: begin
               if (!r_init_we) begin
                  r_init_we <= 1'b1;
               end else if (r_cnt == C_LAST) begin
                  r_init_we <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_RUN;
               end else begin
                  r_cnt <= r_cnt + REG_W'(1);
               end
            end
            S_RUN: begin
               if (halt_req) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!halt_req)      r_state <= S_RUN;
               else if (w_drained) r_state <= S_HALTED;
            end
            S_HALTED: begin
               if (!halt_req) r_state <= S_RUN;
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Self-checking bench for pipeline_hazard_ctrl: directed vector
//             table, hand-written init/halt/reset sequences and randomized
//             traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
   logic        id_use_rn = 1'b0, id_use_rm = 1'b0, id_reg_write = 1'b0;
   logic        ex_branch_taken = 1'b0, wb_reg_write = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        halt_req = 1'b0;
   logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, init_we;
   logic [4:0]  init_addr;
   logic [31:0] init_data;
   logic        ready, halted, sb_err;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic       id_valid;
      logic [4:0] id_rn;
      logic [4:0] id_rm;
      logic [4:0] id_rd;
      logic       use_rn;
      logic       use_rm;
      logic       reg_write;
      logic       br;
      logic       wb_we;
      logic [4:0] wb_rd;
      logic       halt;
   } stim_t;

   typedef struct {
      stim_t s;
      logic  pc;
      logic  fl;
      logic  bub;
      logic  err;
   } vec_t;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_reg_write(id_reg_write),
      .ex_branch_taken(ex_branch_taken), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .halt_req(halt_req),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .init_we(init_we), .init_addr(init_addr),
      .init_data(init_data), .ready(ready), .halted(halted), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   localparam int P_WAIT = 0, P_INIT = 1, P_RUN = 2, P_DRAIN = 3, P_HALT = 4;
   int m_phase = P_WAIT;
   int m_cnt   = 0;
   int m_sb [32];
   bit m_err   = 1'b0;
   int m_cyc   = 0;
   int m_iss [$];      // cycle numbers of issued instructions still in flight

   task automatic m_reset();
      m_phase = P_WAIT;
      m_cnt   = 0;
      m_err   = 1'b0;
      foreach (m_sb[i]) m_sb[i] = 0;
      m_iss.delete();
   endtask

   function automatic bit m_hazard(input stim_t s);
      return s.id_valid && ((s.use_rn && m_sb[s.id_rn] != 0) ||
                            (s.use_rm && m_sb[s.id_rm] != 0) ||
                            (s.reg_write && m_sb[s.id_rd] == 3));
   endfunction

   // {pc_en, if_id_en, if_id_flush, id_ex_bubble, init_we, ready, halted, sb_err}
   function automatic logic [7:0] m_expect(input stim_t s);
      logic pc = 1'b0, en = 1'b0, fl = 1'b0, bub = 1'b1;
      if (m_phase == P_RUN) begin
         if (s.br) begin pc = 1'b1; en = 1'b1; fl = 1'b1; end
         else if (!m_hazard(s)) begin pc = 1'b1; en = 1'b1; bub = 1'b0; end
      end else if (m_phase == P_DRAIN && s.br) begin
         pc = 1'b1; en = 1'b1; fl = 1'b1;
      end
      return {pc, en, fl, bub, (m_phase == P_INIT), (m_phase == P_RUN),
              (m_phase == P_HALT), m_err};
   endfunction

   task automatic m_advance(input stim_t s, input logic r);
      logic [7:0] e;
      bit issue, drained, allzero, inc, dec;
      if (!r) begin m_reset(); m_cyc++; return; end
      e     = m_expect(s);
      issue = s.id_valid && !e[4];
      while (m_iss.size() > 0 && (m_cyc - m_iss[0]) > 3) void'(m_iss.pop_front());
      drained = (m_iss.size() == 0);
      allzero = 1'b1;
      foreach (m_sb[i]) if (m_sb[i] != 0) allzero = 1'b0;
      case (m_phase)
         P_WAIT:  begin m_phase = P_INIT; m_cnt = 0; end
         P_INIT:  if (m_cnt == 31) m_phase = P_RUN; else m_cnt++;
         P_RUN:   if (s.halt) m_phase = P_DRAIN;
         P_DRAIN: if (!s.halt) m_phase = P_RUN;
                  else if (drained && allzero) m_phase = P_HALT;
         P_HALT:  if (!s.halt) m_phase = P_RUN;
         default: ;
      endcase
      inc = issue && s.reg_write;
      dec = s.wb_we;
      if (!(inc && dec && s.id_rd == s.wb_rd)) begin
         if (inc) begin
            if (m_sb[s.id_rd] == 3) m_err = 1'b1; else m_sb[s.id_rd]++;
         end
         if (dec) begin
            if (m_sb[s.wb_rd] == 0) m_err = 1'b1; else m_sb[s.wb_rd]--;
         end
      end
      if (issue) m_iss.push_back(m_cyc);
      m_cyc++;
   endtask

   // ---------------- bench helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic stim_t mk(input bit v, input int rn, input int rm, input int rd,
                                input bit urn, input bit urm, input bit rw, input bit br,
                                input bit wbe, input int wbr, input bit h);
      stim_t s;
      s = '{v, 5'(rn), 5'(rm), 5'(rd), urn, urm, rw, br, wbe, 5'(wbr), h};
      return s;
   endfunction

   function automatic stim_t rand_stim(input bit h);
      stim_t s;
      int    r;
      s           = '0;
      s.id_valid  = ($urandom_range(0, 3) != 0);
      s.id_rn     = 5'($urandom_range(0, 7));
      s.id_rm     = 5'($urandom_range(0, 7));
      s.id_rd     = 5'($urandom_range(0, 7));
      s.use_rn    = 1'($urandom_range(0, 1));
      s.use_rm    = 1'($urandom_range(0, 1));
      s.reg_write = 1'($urandom_range(0, 1));
      s.br        = ($urandom_range(0, 15) == 0);
      r           = int'($urandom_range(0, 7));
      if (m_sb[r] > 0 && $urandom_range(0, 1) == 1) begin
         s.wb_we = 1'b1; s.wb_rd = 5'(r);
      end else if ($urandom_range(0, 499) == 0) begin
         s.wb_we = 1'b1; s.wb_rd = 5'($urandom_range(8, 31));
      end
      s.halt = h;
      return s;
   endfunction

   // Drive one cycle at the falling edge, compare against the model, advance it.
   task automatic step(input stim_t s, input logic r);
      logic [7:0] e, a, m;
      @(negedge clk);
      rst = r;
      id_valid = s.id_valid; id_rn = s.id_rn; id_rm = s.id_rm; id_rd = s.id_rd;
      id_use_rn = s.use_rn; id_use_rm = s.use_rm; id_reg_write = s.reg_write;
      ex_branch_taken = s.br; wb_reg_write = s.wb_we; wb_rd = s.wb_rd; halt_req = s.halt;
      #1;
      e = m_expect(s);
      m = 8'hFF;
      if (s.br && (m_phase == P_RUN || m_phase == P_DRAIN)) m[6] = 1'b0;
      a = {pc_en, if_id_en, if_id_flush, id_ex_bubble, init_we, ready, halted, sb_err};
      check("model_outputs", 64'(a & m), 64'(e & m));
      if (m_phase == P_INIT) check("model_init_addr", 64'(init_addr), 64'(m_cnt));
      m_advance(s, r);
   endtask

   task automatic run_init();
      stim_t idle;
      idle = '0;
      step(idle, 1'b1);
      check("init_first_cycle_we", 64'(init_we), 64'd0);
      for (int i = 0; i < 32; i++) begin
         step(idle, 1'b1);
         check($sformatf("init_write%0d", i), {init_we, init_addr, init_data},
               {1'b1, 5'(i), 32'd0});
      end
      step(idle, 1'b1);
      check("init_done_ready", {init_we, ready}, 2'b01);
   endtask

   vec_t tbl [19];

   initial begin
      stim_t idle;
      bit    hlvl;
      idle = '0;
      hlvl = 1'b0;

      //            v rn rm rd urn urm rw br wbe wbr h     pc fl bub err
      tbl[0]  = '{mk(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{mk(1, 3, 0, 7, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{mk(1, 0, 3, 7, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{mk(1, 3, 0, 7, 1, 0, 0, 1, 0, 0, 0), 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{mk(1, 3, 0, 7, 1, 0, 0, 0, 1, 3, 0), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{mk(1, 3, 0, 7, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{mk(1, 5, 5, 8, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{mk(0, 5, 5, 5, 1, 1, 1, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{mk(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{mk(1, 0, 0, 5, 0, 0, 1, 0, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[18] = '{mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset values, then the register-bank clear sequence.
      m_reset();
      repeat (3) step(idle, 1'b0);
      check("reset_outputs",
            {pc_en, if_id_en, if_id_flush, id_ex_bubble, init_we, init_addr, ready, halted, sb_err},
            {4'b0001, 1'b0, 5'd0, 3'b000});
      run_init();

      // Randomized traffic against the model, with a slowly toggling halt level.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) hlvl = ~hlvl;
         step(rand_stim(hlvl), 1'b1);
      end

      // Back to RUN, leave r9 pending, then reset asynchronously mid-cycle.
      repeat (2) step(idle, 1'b1);
      step(mk(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0), 1'b1);
      step(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1);
      check("pending_r9_stalls", 64'(id_ex_bubble), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("async_reset_outputs",
            {pc_en, if_id_en, if_id_flush, id_ex_bubble, init_we, init_addr, ready, halted, sb_err},
            {4'b0001, 1'b0, 5'd0, 3'b000});
      m_reset();
      repeat (2) step(idle, 1'b0);
      run_init();
      step(mk(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1);
      check("r9_cleared_by_reset", {pc_en, id_ex_bubble}, 2'b10);

      // Directed vector table: RAW stall, flush during stall, saturation, underflow.
      for (int k = 0; k < 19; k++) begin
         step(tbl[k].s, 1'b1);
         check($sformatf("table_row%0d", k), {pc_en, if_id_flush, id_ex_bubble, sb_err},
               {tbl[k].pc, tbl[k].fl, tbl[k].bub, tbl[k].err});
      end

      // Drain/halt: two writers in MEM/WB when halt rises, halted 3 cycles later.
      step(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1);
      step(mk(1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0), 1'b1);
      step(idle, 1'b1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 1'b1);
      check("halt_cycle0", {ready, halted}, 2'b10);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1), 1'b1);
      check("halt_cycle1_drain", {pc_en, id_ex_bubble, ready, halted}, 4'b0100);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
      check("halt_cycle2", 64'(halted), 64'd0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
      check("halt_cycle3_halted", {pc_en, halted}, 2'b01);
      step(idle, 1'b1);
      check("halt_dropped_still_halted", {ready, halted}, 2'b01);
      step(idle, 1'b1);
      check("resume_ready", {ready, halted}, 2'b10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
